// File: rtl/serial_subtractor.sv
`default_nettype none
// =============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial a - b, LSB first, one full-subtractor slice per clock
//            with a single registered borrow and a start/done handshake.
// Revision : 1.0 - initial release
// =============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bq_q, bq_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Full-subtractor slice; the first slice sees bq=0 and acts as a half subtractor.
  logic x, y, bin, d_bit, bout;
  always_comb begin
    x     = ra_q[0];
    y     = rb_q[0];
    bin   = bq_q;
    d_bit = x ^ y ^ bin;
    bout  = (~x & y) | (~(x ^ y) & bin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      diff_q   <= '0;
      bq_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      diff_q   <= diff_d;
      bq_q     <= bq_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    diff_d   = diff_q;
    bq_d     = bq_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d     = a;
          rb_d     = b;
          diff_d   = '0;
          bq_d     = 1'b0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        ra_d   = {1'b0, ra_q[WIDTH-1:1]};
        rb_d   = {1'b0, rb_q[WIDTH-1:1]};
        bq_d   = bout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          borrow_d = bout;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == S_SHIFT);
    done       = (state_q == S_DONE);
    diff       = diff_q;
    borrow_out = borrow_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// Testbench for serial_subtractor: directed WIDTH=8 scenarios plus an
// exhaustive WIDTH=4 sweep on a second instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, borrow4;
  logic [3:0] diff4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4)
  );

  // Launches one WIDTH=8 operation; cycle 1 is the cycle after the accepting edge.
  task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib,
                        output int done_cyc, output int busy_cnt);
    @(negedge clk);
    a8 = ia; b8 = ib; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    done_cyc = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy8); end
    tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done8); end
    tests++; if (diff8 !== 8'h00) begin fails++; $display("FAIL reset_diff got %h want 00", diff8); end
    tests++; if (borrow8 !== 1'b0) begin fails++; $display("FAIL reset_borrow got %b want 0", borrow8); end
    tests++; if ({busy4, done4, borrow4, diff4} !== 7'd0) begin
      fails++; $display("FAIL reset_w4 got %b want 0", {busy4, done4, borrow4, diff4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int dc, bc;
    do_op8(8'h5A, 8'h3C, dc, bc);
    tests++; if (dc !== 9) begin fails++; $display("FAIL basic_latency got %0d want 9", dc); end
    tests++; if (bc !== 8) begin fails++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
    tests++; if (diff8 !== 8'h1E) begin fails++; $display("FAIL basic_diff got %h want 1e", diff8); end
    tests++; if (borrow8 !== 1'b0) begin fails++; $display("FAIL basic_borrow got %b want 0", borrow8); end
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done got %b want 0", busy8); end
    @(negedge clk);
    tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL basic_done_width got %b want 0", done8); end
    tests++; if (diff8 !== 8'h1E) begin fails++; $display("FAIL basic_diff_hold got %h want 1e", diff8); end
  endtask

  task automatic test_corners();
    int dc, bc;
    do_op8(8'h00, 8'h01, dc, bc);
    tests++; if (dc !== 9) begin fails++; $display("FAIL c1_latency got %0d want 9", dc); end
    tests++; if (diff8 !== 8'hFF) begin fails++; $display("FAIL c1_diff got %h want ff", diff8); end
    tests++; if (borrow8 !== 1'b1) begin fails++; $display("FAIL c1_borrow got %b want 1", borrow8); end
    @(negedge clk);
    do_op8(8'h80, 8'h80, dc, bc);
    tests++; if (dc !== 9) begin fails++; $display("FAIL c2_latency got %0d want 9", dc); end
    tests++; if (diff8 !== 8'h00) begin fails++; $display("FAIL c2_diff got %h want 00", diff8); end
    tests++; if (borrow8 !== 1'b0) begin fails++; $display("FAIL c2_borrow got %b want 0", borrow8); end
    @(negedge clk);
  endtask

  task automatic test_exhaustive_w4();
    logic [4:0] exp;
    bit         seen;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      a4 = i[7:4]; b4 = i[3:0]; start4 = 1'b1;
      exp = {1'b0, a4} - {1'b0, b4};
      @(negedge clk);
      start4 = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
        if (done4) seen = 1'b1;
        else @(negedge clk);
      end
      tests++;
      if (!seen) begin
        fails++; $display("FAIL w4_timeout a=%h b=%h got no done want done", i[7:4], i[3:0]);
      end else if ({borrow4, diff4} !== exp) begin
        fails++; $display("FAIL w4_result a=%h b=%h got %b want %b", i[7:4], i[3:0], {borrow4, diff4}, exp);
      end
    end
  endtask

  task automatic test_start_held();
    bit seen;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF;
    seen = 1'b0;
    for (int c = 0; c < 15 && !seen; c++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL held_timeout got no done want done"); end
    tests++; if (diff8 !== 8'h0F) begin fails++; $display("FAIL held_diff got %h want 0f", diff8); end
    tests++; if (borrow8 !== 1'b0) begin fails++; $display("FAIL held_borrow got %b want 0", borrow8); end
    @(negedge clk);
    tests++; if ({busy8, done8} !== 2'b00) begin
      fails++; $display("FAIL held_after_done got busy,done=%b want 00", {busy8, done8});
    end
    @(negedge clk);
    tests++; if (busy8 !== 1'b1) begin fails++; $display("FAIL held_reaccept got %b want 1", busy8); end
    start8 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 15 && !seen; c++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL held2_timeout got no done want done"); end
    tests++; if ({borrow8, diff8} !== 9'h000) begin
      fails++; $display("FAIL held2_result got %h want 000", {borrow8, diff8});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    int dc, bc, ndone;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    tests++; if (busy8 !== 1'b1) begin fails++; $display("FAIL mid_busy_before got %b want 1", busy8); end
    rst_n = 1'b0;
    #1;
    tests++; if ({busy8, done8, borrow8, diff8} !== 11'd0) begin
      fails++; $display("FAIL mid_async_clear got %h want 000", {busy8, done8, borrow8, diff8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    tests++; if (ndone !== 0) begin fails++; $display("FAIL mid_no_done got %0d want 0", ndone); end
    do_op8(8'hC8, 8'h64, dc, bc);
    tests++; if (dc !== 9) begin fails++; $display("FAIL post_latency got %0d want 9", dc); end
    tests++; if (diff8 !== 8'h64) begin fails++; $display("FAIL post_diff got %h want 64", diff8); end
    tests++; if (borrow8 !== 1'b0) begin fails++; $display("FAIL post_borrow got %b want 0", borrow8); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_exhaustive_w4();
    test_start_held();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
